// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per cycle,
// registered carry chain, valid/ready handshakes on both sides.
module serial_add_sub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             carry,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             c_q, c_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DIGIT:0]   dsum;
   logic             msb_cin;

   // One digit slice of the carry chain; msb_cin is the carry into the top
   // bit of the current digit, meaningful on the last digit.
   always_comb begin
      dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, c_q};
      msb_cin = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
   end

   // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      y_d     = y_q;
      c_d     = c_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               c_d     = sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            r_d   = WIDTH'({dsum[DIGIT-1:0], r_q} >> DIGIT);
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            c_d   = dsum[DIGIT];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               y_d     = r_d;
               carry_d = dsum[DIGIT];
               ovf_d   = msb_cin ^ dsum[DIGIT];
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         y_q     <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         y_q     <= y_d;
         c_q     <= c_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign y         = y_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and swept checks for serial_add_sub: vector table on a DIGIT=4
// instance, multi-cycle corner sequences, and random sweep over DIGIT.
module tb_serial_add_sub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;
   logic        carry, overflow;

   logic            sw_in_valid;
   logic            sw_out_ready;
   logic [3:0]      sw_in_ready;
   logic [3:0]      sw_out_valid;
   logic [3:0][15:0] sw_y;
   logic [3:0]      sw_carry;
   logic [3:0]      sw_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .carry(carry), .overflow(overflow)
   );

   function automatic int dig_of(int k);
      case (k)
         0: return 1;
         1: return 2;
         2: return 8;
         default: return 16;
      endcase
   endfunction

   for (genvar k = 0; k < 4; k++) begin : g_sw
      serial_add_sub #(.WIDTH(16), .DIGIT(dig_of(k))) u_sw (
         .clk(clk), .rst_n(rst_n),
         .in_valid(sw_in_valid), .in_ready(sw_in_ready[k]),
         .a(a), .b(b), .sub(sub),
         .out_valid(sw_out_valid[k]), .out_ready(sw_out_ready),
         .y(sw_y[k]), .carry(sw_carry[k]), .overflow(sw_ovf[k])
      );
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] y;
      logic        c;
      logic        o;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent reference: full-width add, sign-rule overflow.
   task automatic ref_model(input logic [15:0] ra, input logic [15:0] rb,
                            input logic rs, output logic [15:0] ry,
                            output logic rc, output logic ro);
      logic [16:0] s;
      if (rs) s = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
      else    s = {1'b0, ra} + {1'b0, rb};
      ry = s[15:0];
      rc = s[16];
      if (rs) ro = (ra[15] != rb[15]) && (ry[15] != ra[15]);
      else    ro = (ra[15] == rb[15]) && (ry[15] != ra[15]);
   endtask

   // Issue one op on the main DUT; returns edges until out_valid (0 = timeout).
   task automatic start_op(input logic [15:0] oa, input logic [15:0] ob,
                           input logic os, output int lat);
      lat = 0;
      chk("in_ready_before_op", 32'(in_ready), 32'd1);
      a = oa; b = ob; sub = os; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      for (int e = 1; e <= 10; e++) begin
         if (out_valid) break;
         if (e > 1) ;
         if (lat == 0) begin
            step();
            if (out_valid) lat = e;
         end
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("out_valid_after_pop", 32'(out_valid), 32'd0);
      chk("in_ready_after_pop", 32'(in_ready), 32'd1);
   endtask

   initial begin
      vec_t vt[10];
      int lat;
      logic [15:0] hy;
      logic hc, ho;
      logic [15:0] ey;
      logic ec, eo;

      vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vt[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
      vt[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vt[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
      vt[8] = '{16'h0003, 16'h0002, 1'b1, 16'h0001, 1'b1, 1'b0};
      vt[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0;
      sw_in_valid = 1'b0; sw_out_ready = 1'b0;
      step();
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_flags", {30'd0, carry, overflow}, 32'd0);
      rst_n = 1'b1;
      step();

      // Vector table
      for (int i = 0; i < 10; i++) begin
         start_op(vt[i].a, vt[i].b, vt[i].sub, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
         chk($sformatf("v%0d_y", i), 32'(y), 32'(vt[i].y));
         chk($sformatf("v%0d_carry", i), 32'(carry), 32'(vt[i].c));
         chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vt[i].o));
         pop();
      end

      // Stall in DONE with new operands offered
      start_op(16'h1234, 16'h1111, 1'b0, lat);
      chk("stall_latency", 32'(lat), 32'd4);
      in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_y", 32'(y), 32'h2345);
         chk("stall_flags", {30'd0, carry, overflow}, 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      pop();
      start_op(16'h0001, 16'h0002, 1'b0, lat);
      chk("post_stall_latency", 32'(lat), 32'd4);
      chk("post_stall_y", 32'(y), 32'h0003);
      pop();

      // Back-to-back: accept on the cycle right after the pop
      start_op(16'h00F0, 16'h000F, 1'b0, lat);
      chk("b2b_y", 32'(y), 32'h00FF);
      pop();

      // Reset during the second RUN cycle
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_y", 32'(y), 32'd0);
      chk("midrst_flags", {30'd0, carry, overflow}, 32'd0);
      start_op(16'h1234, 16'h1111, 1'b0, lat);
      chk("midrst_op_latency", 32'(lat), 32'd4);
      chk("midrst_op_y", 32'(y), 32'h2345);
      chk("midrst_op_flags", {30'd0, carry, overflow}, 32'd0);
      pop();

      // Random sweep across DIGIT = 1, 2, 8, 16
      for (int it = 0; it < 1000; it++) begin
         int slat[4];
         logic [15:0] ra, rb;
         logic rs;
         ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
         if (it == 0) begin ra = 16'hFFFF; rb = 16'h0001; rs = 1'b0; end
         if (it == 1) begin ra = 16'h8000; rb = 16'h0001; rs = 1'b1; end
         ref_model(ra, rb, rs, ey, ec, eo);
         chk("sw_in_ready", 32'(sw_in_ready), 32'hF);
         a = ra; b = rb; sub = rs; sw_in_valid = 1'b1;
         step();
         sw_in_valid = 1'b0;
         a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
         for (int k = 0; k < 4; k++) slat[k] = 0;
         for (int e = 1; e <= 16; e++) begin
            step();
            for (int k = 0; k < 4; k++)
               if (sw_out_valid[k] && slat[k] == 0) slat[k] = e;
         end
         for (int k = 0; k < 4; k++) begin
            hy = sw_y[k]; hc = sw_carry[k]; ho = sw_ovf[k];
            chk($sformatf("sw_d%0d_latency", dig_of(k)), 32'(slat[k]),
                32'(16 / dig_of(k)));
            chk($sformatf("sw_d%0d_y", dig_of(k)), 32'(hy), 32'(ey));
            chk($sformatf("sw_d%0d_flags", dig_of(k)), {30'd0, hc, ho},
                {30'd0, ec, eo});
         end
         sw_out_ready = 1'b1;
         step();
         sw_out_ready = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
